// File: rtl/ulss_pkt_scheduler.sv
// ulss_pkt_scheduler: 16-store, 4-lane weighted round-robin packet scheduler.
// Optional per-lane transfer watchdog enabled by defining ULSS_SCH_XFER_TIMEOUT_EN.
module ulss_pkt_scheduler #(
  parameter int NUM_IN      = 16,
  parameter int NUM_LANE    = 4,
  parameter int WEIGHT_W    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   rate_limiter_16to4_clk,
  input  logic                   rate_limiter_16to4_rstn,
  input  logic                   rate_limiter_16to4_sw_rst,
  input  logic                   sch_reg_wr_en,
  input  logic [4:0]             sch_reg_wr_addr,
  input  logic [63:0]            sch_reg_wr_data,
  input  logic [NUM_IN-1:0]      pck_str_empty,
  input  logic [NUM_IN-1:0]      pck_str_eop,
  output logic [NUM_IN-1:0]      pck_rd_en_grnt,
  output logic [4*NUM_LANE-1:0]  lane_src,
  output logic [NUM_LANE-1:0]    lane_busy,
  output logic [NUM_LANE-1:0]    sch_timeout_err
);
  localparam int SW = $clog2(NUM_IN);
  localparam int LW = $clog2(NUM_LANE);
  localparam int CW = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, SEL, XFER} state_t;
  logic [LW-1:0]       map_q    [NUM_IN];
  logic [WEIGHT_W-1:0] weight_q [NUM_IN];
  logic                sch_en_q;
  state_t              state_q  [NUM_LANE];
  state_t              state_d  [NUM_LANE];
  logic [SW-1:0]       ptr_q    [NUM_LANE];
  logic [SW-1:0]       ptr_d    [NUM_LANE];
  logic [SW-1:0]       src_q    [NUM_LANE];
  logic [SW-1:0]       src_d    [NUM_LANE];
  logic [WEIGHT_W-1:0] credit_q [NUM_LANE];
  logic [WEIGHT_W-1:0] credit_d [NUM_LANE];
  logic [NUM_IN-1:0]   held     [NUM_LANE];
  logic [NUM_IN-1:0]   elig     [NUM_LANE];
  logic [SW-1:0]       pick     [NUM_LANE];
  logic [NUM_LANE-1:0] found;
  logic [NUM_IN-1:0]   all_held;
  logic                unused_data;
  assign unused_data = ^{sch_reg_wr_data[63:8], sch_reg_wr_data[3:2]};
`ifdef ULSS_SCH_XFER_TIMEOUT_EN
  logic [CW-1:0]       cnt_q [NUM_LANE];
  logic [CW-1:0]       cnt_d [NUM_LANE];
  logic [NUM_LANE-1:0] err_q, err_d;
  logic                clr_err;
  assign clr_err = sch_reg_wr_en && sch_reg_wr_addr == 5'd16 && sch_reg_wr_data[1];
  assign sch_timeout_err = err_q;
`else
  logic [CW-1:0] unused_cnt;
  assign unused_cnt = '0;
  assign sch_timeout_err = '0;
`endif
  always_ff @(posedge rate_limiter_16to4_clk or negedge rate_limiter_16to4_rstn)
    if (!rate_limiter_16to4_rstn) begin
      for (int i = 0; i < NUM_IN; i++) begin
        map_q[i]    <= LW'(i >> 2);
        weight_q[i] <= WEIGHT_W'(1);
      end
      sch_en_q <= 1'b0;
    end else if (sch_reg_wr_en) begin
      if (!sch_reg_wr_addr[4]) begin
        map_q[sch_reg_wr_addr[3:0]]    <= sch_reg_wr_data[LW-1:0];
        weight_q[sch_reg_wr_addr[3:0]] <= sch_reg_wr_data[4+:WEIGHT_W];
      end else if (sch_reg_wr_addr[3:0] == 4'd0)
        sch_en_q <= sch_reg_wr_data[0];
    end
  // A store stays owned by the lane serving it, even across a remap, until its EOP.
  always_comb begin
    all_held = '0;
    for (int l = 0; l < NUM_LANE; l++) begin
      held[l] = (state_q[l] == XFER || (state_q[l] == SEL && credit_q[l] != '0)) ? NUM_IN'(1) << src_q[l] : '0;
      all_held |= held[l];
    end
    pck_rd_en_grnt = '0;
`ifdef ULSS_SCH_XFER_TIMEOUT_EN
    err_d = clr_err ? '0 : err_q;
`endif
    for (int l = 0; l < NUM_LANE; l++) begin
      for (int i = 0; i < NUM_IN; i++)
        elig[l][i] = sch_en_q && map_q[i] == LW'(l) && weight_q[i] != '0 && !pck_str_empty[i] && !(all_held[i] && !held[l][i]);
      found[l] = 1'b0;
      pick[l]  = '0;
      for (int j = NUM_IN - 1; j >= 0; j--)
        if (elig[l][ptr_q[l] + SW'(j)]) begin
          found[l] = 1'b1;
          pick[l]  = ptr_q[l] + SW'(j);
        end
      state_d[l]  = state_q[l];
      ptr_d[l]    = ptr_q[l];
      src_d[l]    = src_q[l];
      credit_d[l] = credit_q[l];
`ifdef ULSS_SCH_XFER_TIMEOUT_EN
      cnt_d[l] = cnt_q[l];
`endif
      lane_src[SW*l+:SW] = src_q[l];
      lane_busy[l] = state_q[l] == XFER;
      case (state_q[l])
        IDLE: state_d[l] = (|elig[l]) ? SEL : IDLE;
        SEL: begin
`ifdef ULSS_SCH_XFER_TIMEOUT_EN
          cnt_d[l] = '0;
`endif
          // Nonzero credit here means a reselect of the store just served.
          if (credit_q[l] != '0) begin
            state_d[l] = elig[l][src_q[l]] ? XFER : IDLE;
            if (!elig[l][src_q[l]]) begin
              ptr_d[l]    = src_q[l] + 1'b1;
              credit_d[l] = '0;
            end
          end else if (found[l]) begin
            src_d[l]    = pick[l];
            credit_d[l] = weight_q[pick[l]];
            state_d[l]  = XFER;
          end else
            state_d[l] = IDLE;
        end
        XFER: begin
          pck_rd_en_grnt[src_q[l]] = !pck_str_empty[src_q[l]];
          if (!pck_str_empty[src_q[l]] && pck_str_eop[src_q[l]]) begin
            credit_d[l] = credit_q[l] - 1'b1;
            state_d[l]  = credit_q[l] == WEIGHT_W'(1) ? IDLE : SEL;
            ptr_d[l]    = credit_q[l] == WEIGHT_W'(1) ? src_q[l] + 1'b1 : ptr_q[l];
          end
`ifdef ULSS_SCH_XFER_TIMEOUT_EN
          else if (cnt_q[l] == CW'(TIMEOUT_CYC - 1)) begin
            err_d[l]    = 1'b1;
            ptr_d[l]    = src_q[l] + 1'b1;
            credit_d[l] = '0;
            state_d[l]  = IDLE;
          end else
            cnt_d[l] = cnt_q[l] + 1'b1;
`endif
        end
        default: state_d[l] = IDLE;
      endcase
    end
  end
  always_ff @(posedge rate_limiter_16to4_clk or negedge rate_limiter_16to4_rstn)
    if (!rate_limiter_16to4_rstn)
      for (int l = 0; l < NUM_LANE; l++) begin
        state_q[l]  <= IDLE;
        ptr_q[l]    <= '0;
        src_q[l]    <= '0;
        credit_q[l] <= '0;
      end
    else
      for (int l = 0; l < NUM_LANE; l++) begin
        state_q[l]  <= rate_limiter_16to4_sw_rst ? IDLE : state_d[l];
        ptr_q[l]    <= rate_limiter_16to4_sw_rst ? '0 : ptr_d[l];
        src_q[l]    <= rate_limiter_16to4_sw_rst ? '0 : src_d[l];
        credit_q[l] <= rate_limiter_16to4_sw_rst ? '0 : credit_d[l];
      end
`ifdef ULSS_SCH_XFER_TIMEOUT_EN
  always_ff @(posedge rate_limiter_16to4_clk or negedge rate_limiter_16to4_rstn)
    if (!rate_limiter_16to4_rstn) begin
      err_q <= '0;
      for (int l = 0; l < NUM_LANE; l++) cnt_q[l] <= '0;
    end else begin
      err_q <= rate_limiter_16to4_sw_rst ? '0 : err_d;
      for (int l = 0; l < NUM_LANE; l++) cnt_q[l] <= rate_limiter_16to4_sw_rst ? '0 : cnt_d[l];
    end
`endif
endmodule

// File: tb/tb_ulss_pkt_scheduler.sv
// tb_ulss_pkt_scheduler: directed scoreboard bench; packet-store model drives empty/EOP and checks granted packets per lane.
module tb_ulss_pkt_scheduler;
  logic clk = 1'b0, rstn = 1'b0, sw_rst = 1'b0, wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [15:0] empty, eop, grnt, lsrc;
  logic [3:0]  busy, terr, busy_or;
  int added [16], done [16], len [16], pos [16];
  bit stall [16];
  int exp_q [4][$];
  int tests = 0, fails = 0, mon_own, mon_lane, cnt;

  always #5 clk = ~clk;

  ulss_pkt_scheduler #(.TIMEOUT_CYC(16)) dut (
    .rate_limiter_16to4_clk(clk),
    .rate_limiter_16to4_rstn(rstn),
    .rate_limiter_16to4_sw_rst(sw_rst),
    .sch_reg_wr_en(wr_en),
    .sch_reg_wr_addr(wr_addr),
    .sch_reg_wr_data(wr_data),
    .pck_str_empty(empty),
    .pck_str_eop(eop),
    .pck_rd_en_grnt(grnt),
    .lane_src(lsrc),
    .lane_busy(busy),
    .sch_timeout_err(terr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 16; i++) begin
      empty[i] = (added[i] == done[i]) || stall[i];
      eop[i]   = pos[i] == len[i] - 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    refresh();
    #1;
  endtask

  task automatic add(input int s, input int n, input int l);
    len[s] = l;
    added[s] += n;
    refresh();
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = 5'(a);
    wr_data = 64'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_busy(input int l, input int maxc);
    int c = 0;
    while (!busy[l] && c < maxc) begin
      tick();
      c++;
    end
    chk($sformatf("busy%0d_wait", l), 32'(busy[l]), 1);
  endtask

  task automatic wait_drain(input int maxc);
    int c = 0;
    busy_or = '0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) > 0 && c < maxc) begin
      tick();
      busy_or |= busy;
      c++;
    end
    chk("drain", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);
  endtask

  // Packet handshake model: a word moves on grant && !empty; EOP retires the packet and is scored per lane.
  always @(posedge clk)
    for (int i = 0; i < 16; i++)
      if (grnt[i] && !empty[i]) begin
        if (eop[i]) begin
          mon_own = 0;
          mon_lane = -1;
          for (int k = 0; k < 4; k++)
            if (busy[k] && lsrc[4*k+:4] == 4'(i)) begin
              mon_own++;
              mon_lane = k;
            end
          chk($sformatf("owner_s%0d", i), mon_own, 1);
          if (mon_lane >= 0) begin
            if (exp_q[mon_lane].size() == 0) chk($sformatf("unexpected_pkt_lane%0d", mon_lane), i, -1);
            else chk($sformatf("lane%0d_store", mon_lane), i, exp_q[mon_lane].pop_front());
          end
          done[i]++;
          pos[i] = 0;
        end else
          pos[i]++;
      end

  initial begin
    for (int i = 0; i < 16; i++) len[i] = 1;
    refresh();
    repeat (3) tick();
    rstn = 1'b1;
    chk("rst_grant", grnt, 0);
    chk("rst_src", lsrc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", terr, 0);
    wr(16, 1);
    exp_q[0].push_back(0);
    add(0, 1, 1);
    tick();
    chk("lat_sel_nogrant", grnt, 0);
    tick();
    chk("lat_grant", grnt, 16'h0001);
    chk("lat_busy", busy, 4'h1);
    wait_drain(20);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      exp_q[0].push_back(s);
      add(s, 1, 1);
    end
    wait_drain(60);
    chk("lanes123_idle", busy_or[3:1], 0);
    wr(0, 'h30);
    wr(1, 'h10);
    exp_q[0] = '{0, 0, 0, 1, 0, 0, 0, 1};
    add(0, 6, 1);
    add(1, 2, 1);
    wait_drain(100);
    exp_q[1].push_back(5);
    add(5, 1, 4);
    wait_busy(1, 20);
    exp_q[0].push_back(5);
    add(5, 1, 4);
    wr(5, 'h10);
    wait_drain(100);
    exp_q[0].push_back(2);
    add(2, 1, 4);
    wait_busy(0, 20);
    tick();
    stall[2] = 1'b1;
    refresh();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_grant", grnt[2], 0);
      chk("stall_busy", busy[0], 1);
      tick();
    end
    stall[2] = 1'b0;
    refresh();
    wait_drain(50);
    exp_q[3].push_back(12);
    add(12, 2, 3);
    wait_busy(3, 20);
    wr(16, 0);
    repeat (10) tick();
    chk("en_off_done", done[12], 1);
    chk("en_off_idle", busy[3], 0);
    exp_q[3].push_back(12);
    wr(16, 1);
    wait_drain(50);
    exp_q[2].push_back(8);
    add(8, 1, 8);
    wait_busy(2, 20);
    tick();
    tick();
    rstn = 1'b0;
    #1;
    chk("async_rst_grant", grnt, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_src", lsrc, 0);
    tick();
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_nogrant", grnt, 0);
    end
    wr(16, 1);
    wait_drain(50);
`ifdef ULSS_SCH_XFER_TIMEOUT_EN
    add(4, 1, 1000);
    wait_busy(1, 20);
    cnt = 0;
    while (grnt[4] && cnt < 100) begin
      cnt++;
      tick();
    end
    stall[4] = 1'b1;
    refresh();
    #1;
    chk("timeout_grant_cycles", cnt, 16);
    chk("timeout_err_set", terr, 4'b0010);
    chk("timeout_lane_idle", busy[1], 0);
    wr(16, 3);
    chk("timeout_err_clr", terr, 0);
`else
    chk("no_timeout_err", terr, 0);
`endif
    chk("leftover", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
